// File: rtl/modn_timer_digit_if.sv
// Bus between a timer digit and whatever drives or consumes it: load/enable
// inputs, count and carry/status outputs.
interface modn_timer_digit_if #(
   parameter int WIDTH = 4
);
   logic             loadn;
   logic             enable;
   logic [WIDTH-1:0] input_number;
   logic [WIDTH-1:0] output_number;
   logic             tc;
   logic             zero;
   logic             done;

   modport master (
      output loadn, enable, input_number,
      input  output_number, tc, zero, done
   );

   modport slave (
      input  loadn, enable, input_number,
      output output_number, tc, zero, done
   );
endinterface

// File: rtl/modn_timer_digit.sv
// Loadable modulo-N up/down digit counter with a cascade carry/borrow (tc),
// a zero flag, and an optional stop-at-terminal mode with a sticky done flag.
module modn_timer_digit #(
   parameter int WIDTH       = 4,
   parameter int MODULUS     = 10,
   parameter int UP          = 0,
   parameter int STOP_AT_END = 0
) (
   input logic               clock,
   input logic               clearn,
   modn_timer_digit_if.slave bus
);
   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] TERM = (UP != 0) ? LAST : '0;
   localparam logic [WIDTH:0]   MODW = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] count, count_nxt, load_val;
   logic             done_q, done_nxt, at_term;

   // Out-of-range loads saturate so the count never leaves 0..MODULUS-1.
   assign load_val = ({1'b0, bus.input_number} >= MODW) ? LAST : bus.input_number;
   assign at_term  = (count == TERM);

   always_comb begin
      count_nxt = count;
      done_nxt  = done_q;
      if (!bus.loadn) begin
         count_nxt = load_val;
         done_nxt  = 1'b0;
      end else if (bus.enable && !done_q) begin
         if (!at_term)
            count_nxt = (UP != 0) ? count + WIDTH'(1) : count - WIDTH'(1);
         else if (STOP_AT_END != 0)
            done_nxt = 1'b1;
         else
            count_nxt = (UP != 0) ? '0 : LAST;
      end
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         count  <= '0;
         done_q <= 1'b0;
      end else begin
         count  <= count_nxt;
         done_q <= done_nxt;
      end
   end

   // tc is gated by done so a held terminal count carries only once.
   assign bus.output_number = count;
   assign bus.tc            = bus.enable & at_term & ~done_q;
   assign bus.zero          = (count == '0);
   assign bus.done          = done_q;
endmodule
